// File: rtl/core_wb_port_arbiter.sv
// Register-file write-port arbiter: WB stage has priority, MDU results wait in a
// small FIFO with per-entry live bits for WAW kill and a starvation escape state.
module core_wb_port_arbiter #(
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 8,
    parameter int RFIDX_W      = 5,
    parameter int DATA_W       = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               wb_valid_i,
    input  logic [RFIDX_W-1:0] wb_idx_i,
    input  logic [DATA_W-1:0]  wb_data_i,
    output logic               wb_stall_o,
    input  logic               mdu_valid_i,
    output logic               mdu_ready_o,
    input  logic [RFIDX_W-1:0] mdu_idx_i,
    input  logic [DATA_W-1:0]  mdu_data_i,
    output logic               rf_we_o,
    output logic [RFIDX_W-1:0] rf_idx_o,
    output logic [DATA_W-1:0]  rf_data_o,
    output logic               busy_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam int AGE_W = $clog2(STARVE_LIMIT + 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_PEND  = 2'd1;
    localparam logic [1:0] ST_FORCE = 2'd2;

    logic [RFIDX_W-1:0] fifo_idx  [DEPTH];
    logic [DATA_W-1:0]  fifo_data [DEPTH];
    logic [DEPTH-1:0]   fifo_live;
    logic [DEPTH-1:0]   live_nxt;
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr;
    logic [CNT_W-1:0]   count;
    logic [CNT_W-1:0]   count_nxt;
    logic [AGE_W-1:0]   age;
    logic [AGE_W-1:0]   age_nxt;
    logic [1:0]         state;
    logic [1:0]         state_nxt;

    logic               fifo_empty;
    logic               head_live;
    logic               wb_grant;
    logic               pop;
    logic               push;
    logic               push_live;
    logic               rf_we_nxt;
    logic [RFIDX_W-1:0] rf_idx_nxt;
    logic [DATA_W-1:0]  rf_data_nxt;

    assign fifo_empty  = (count == '0);
    assign head_live   = !fifo_empty && fifo_live[rd_ptr];
    assign mdu_ready_o = (count < CNT_W'(DEPTH));
    assign busy_o      = !fifo_empty;
    assign push        = mdu_valid_i && mdu_ready_o;

    // While forced, WB is stalled and the head owns the port.
    assign wb_grant  = (state != ST_FORCE) && wb_valid_i && (wb_idx_i != '0);
    assign pop       = !wb_grant && !fifo_empty;
    assign push_live = (mdu_idx_i != '0) && !(wb_grant && (mdu_idx_i == wb_idx_i));
    assign count_nxt = count + CNT_W'(push) - CNT_W'(pop);

    always_comb begin
        rf_we_nxt   = 1'b0;
        rf_idx_nxt  = wb_idx_i;
        rf_data_nxt = wb_data_i;
        if (wb_grant) begin
            rf_we_nxt = 1'b1;
        end else if (pop && head_live) begin
            rf_we_nxt   = 1'b1;
            rf_idx_nxt  = fifo_idx[rd_ptr];
            rf_data_nxt = fifo_data[rd_ptr];
        end
    end

    // A granted WB write makes any older buffered result to the same register stale.
    always_comb begin
        live_nxt = fifo_live;
        for (int i = 0; i < DEPTH; i++) begin
            if (wb_grant && (fifo_idx[i] == wb_idx_i)) begin
                live_nxt[i] = 1'b0;
            end
        end
        if (push) begin
            live_nxt[wr_ptr] = push_live;
        end
    end

    always_comb begin
        if (pop || !head_live) begin
            age_nxt = '0;
        end else if (age < AGE_W'(STARVE_LIMIT)) begin
            age_nxt = age + AGE_W'(1);
        end else begin
            age_nxt = age;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (push) state_nxt = ST_PEND;
            end
            ST_PEND: begin
                if (pop && (count == CNT_W'(1)) && !push) begin
                    state_nxt = ST_IDLE;
                end else if (!pop && (age == AGE_W'(STARVE_LIMIT - 1))) begin
                    state_nxt = ST_FORCE;
                end
            end
            ST_FORCE: begin
                state_nxt = (count_nxt != '0) ? ST_PEND : ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            count      <= '0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            age        <= '0;
            fifo_live  <= '0;
            wb_stall_o <= 1'b0;
            rf_we_o    <= 1'b0;
            rf_idx_o   <= '0;
            rf_data_o  <= '0;
        end else begin
            state      <= state_nxt;
            count      <= count_nxt;
            age        <= age_nxt;
            fifo_live  <= live_nxt;
            wb_stall_o <= (state_nxt == ST_FORCE);
            rf_we_o    <= rf_we_nxt;
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (rf_we_nxt) begin
                rf_idx_o  <= rf_idx_nxt;
                rf_data_o <= rf_data_nxt;
            end
        end
    end

    // Payload storage needs no reset: the live bits and count qualify it.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_idx[wr_ptr]  <= mdu_idx_i;
            fifo_data[wr_ptr] <= mdu_data_i;
        end
    end

endmodule

// File: tb/tb_core_wb_port_arbiter.sv
// Bench for core_wb_port_arbiter: directed vector table, hand-written starvation
// and reset sequences, then random traffic against a queue-based reference model.
module tb_core_wb_port_arbiter;

    localparam int DEPTH = 2;
    localparam int LIMIT = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wb_valid;
    logic [4:0]  wb_idx;
    logic [31:0] wb_data;
    logic        wb_stall;
    logic        mdu_valid;
    logic        mdu_ready;
    logic [4:0]  mdu_idx;
    logic [31:0] mdu_data;
    logic        rf_we;
    logic [4:0]  rf_idx;
    logic [31:0] rf_data;
    logic        busy;

    core_wb_port_arbiter #(
        .DEPTH(DEPTH), .STARVE_LIMIT(LIMIT), .RFIDX_W(5), .DATA_W(32)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .wb_valid_i(wb_valid), .wb_idx_i(wb_idx), .wb_data_i(wb_data),
        .wb_stall_o(wb_stall),
        .mdu_valid_i(mdu_valid), .mdu_ready_o(mdu_ready),
        .mdu_idx_i(mdu_idx), .mdu_data_i(mdu_data),
        .rf_we_o(rf_we), .rf_idx_o(rf_idx), .rf_data_o(rf_data),
        .busy_o(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        wv;
        logic [4:0]  wi;
        logic [31:0] wd;
        logic        mv;
        logic [4:0]  mi;
        logic [31:0] md;
        logic        we;
        logic [4:0]  idx;
        logic [31:0] data;
        logic        stall;
        logic        busy;
        logic        ready;
    } vec_t;

    typedef struct {
        logic [4:0]  idx;
        logic [31:0] data;
        bit          live;
    } ent_t;

    int n_vec = 0;
    int n_bad = 0;

    vec_t tbl[20];

    ent_t        mq[$];
    int          m_age;
    bit          m_force;
    logic        m_we;
    logic [4:0]  m_idx;
    logic [31:0] m_data;

    function automatic vec_t mk(logic wv, logic [4:0] wi, logic [31:0] wd,
                                logic mv, logic [4:0] mi, logic [31:0] md,
                                logic we, logic [4:0] idx, logic [31:0] data,
                                logic stall, logic bsy, logic ready);
        vec_t v;
        v.wv = wv; v.wi = wi; v.wd = wd;
        v.mv = mv; v.mi = mi; v.md = md;
        v.we = we; v.idx = idx; v.data = data;
        v.stall = stall; v.busy = bsy; v.ready = ready;
        return v;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_out(string tag, logic we, logic [4:0] idx, logic [31:0] data,
                             logic stall, logic bsy, logic ready);
        chk({tag, "_we"},    32'(rf_we),     32'(we));
        chk({tag, "_idx"},   32'(rf_idx),    32'(idx));
        chk({tag, "_data"},  rf_data,        data);
        chk({tag, "_stall"}, 32'(wb_stall),  32'(stall));
        chk({tag, "_busy"},  32'(busy),      32'(bsy));
        chk({tag, "_ready"}, 32'(mdu_ready), 32'(ready));
    endtask

    task automatic set_in(logic wv, logic [4:0] wi, logic [31:0] wd,
                          logic mv, logic [4:0] mi, logic [31:0] md);
        wb_valid = wv; wb_idx = wi; wb_data = wd;
        mdu_valid = mv; mdu_idx = mi; mdu_data = md;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: an ordered list of pending results, WB-first grant, starvation escape.
    task automatic model_step();
        int   n;
        bit   hl;
        bit   wbg;
        bit   pop;
        bit   fnext;
        ent_t h;
        n    = mq.size();
        hl   = (n > 0) && mq[0].live;
        wbg  = !m_force && wb_valid && (wb_idx != 5'd0);
        pop  = 1'b0;
        m_we = 1'b0;
        if (wbg) begin
            m_we = 1'b1; m_idx = wb_idx; m_data = wb_data;
            foreach (mq[k]) if (mq[k].idx == wb_idx) mq[k].live = 1'b0;
        end else if (n > 0) begin
            pop = 1'b1;
            h = mq.pop_front();
            if (h.live) begin
                m_we = 1'b1; m_idx = h.idx; m_data = h.data;
            end
        end
        fnext = !m_force && (n > 0) && !pop && (m_age == LIMIT - 1);
        if (pop || !hl) m_age = 0;
        else if (m_age < LIMIT) m_age++;
        if (mdu_valid && (n < DEPTH))
            mq.push_back('{mdu_idx, mdu_data,
                           (mdu_idx != 5'd0) && !(wbg && (mdu_idx == wb_idx))});
        m_force = fnext;
    endtask

    initial begin
        int  stall_cnt;
        bit  rdy;
        bit  stuck;
        int  phase;

        tbl[0]  = mk(1'b1, 5'd5,  32'hA5,   1'b0, 5'd0,  32'h0,    1'b1, 5'd5,  32'hA5,   1'b0, 1'b0, 1'b1);
        tbl[1]  = mk(1'b1, 5'd5,  32'hA5,   1'b0, 5'd0,  32'h0,    1'b1, 5'd5,  32'hA5,   1'b0, 1'b0, 1'b1);
        tbl[2]  = mk(1'b1, 5'd5,  32'hA5,   1'b0, 5'd0,  32'h0,    1'b1, 5'd5,  32'hA5,   1'b0, 1'b0, 1'b1);
        tbl[3]  = mk(1'b0, 5'd0,  32'h0,    1'b1, 5'd7,  32'h1234, 1'b0, 5'd5,  32'hA5,   1'b0, 1'b1, 1'b1);
        tbl[4]  = mk(1'b0, 5'd0,  32'h0,    1'b0, 5'd0,  32'h0,    1'b1, 5'd7,  32'h1234, 1'b0, 1'b0, 1'b1);
        tbl[5]  = mk(1'b0, 5'd0,  32'h0,    1'b0, 5'd0,  32'h0,    1'b0, 5'd7,  32'h1234, 1'b0, 1'b0, 1'b1);
        tbl[6]  = mk(1'b1, 5'd3,  32'h33,   1'b1, 5'd10, 32'h0A,   1'b1, 5'd3,  32'h33,   1'b0, 1'b1, 1'b1);
        tbl[7]  = mk(1'b1, 5'd3,  32'h33,   1'b1, 5'd11, 32'h0B,   1'b1, 5'd3,  32'h33,   1'b0, 1'b1, 1'b0);
        tbl[8]  = mk(1'b1, 5'd3,  32'h33,   1'b1, 5'd12, 32'h0C,   1'b1, 5'd3,  32'h33,   1'b0, 1'b1, 1'b0);
        tbl[9]  = mk(1'b0, 5'd0,  32'h0,    1'b1, 5'd12, 32'h0C,   1'b1, 5'd10, 32'h0A,   1'b0, 1'b1, 1'b1);
        tbl[10] = mk(1'b0, 5'd0,  32'h0,    1'b1, 5'd12, 32'h0C,   1'b1, 5'd11, 32'h0B,   1'b0, 1'b1, 1'b1);
        tbl[11] = mk(1'b0, 5'd0,  32'h0,    1'b0, 5'd0,  32'h0,    1'b1, 5'd12, 32'h0C,   1'b0, 1'b0, 1'b1);
        tbl[12] = mk(1'b0, 5'd0,  32'h0,    1'b1, 5'd9,  32'h11,   1'b0, 5'd12, 32'h0C,   1'b0, 1'b1, 1'b1);
        tbl[13] = mk(1'b1, 5'd9,  32'h22,   1'b0, 5'd0,  32'h0,    1'b1, 5'd9,  32'h22,   1'b0, 1'b1, 1'b1);
        tbl[14] = mk(1'b0, 5'd0,  32'h0,    1'b0, 5'd0,  32'h0,    1'b0, 5'd9,  32'h22,   1'b0, 1'b0, 1'b1);
        tbl[15] = mk(1'b0, 5'd0,  32'h0,    1'b0, 5'd0,  32'h0,    1'b0, 5'd9,  32'h22,   1'b0, 1'b0, 1'b1);
        tbl[16] = mk(1'b1, 5'd0,  32'hFF,   1'b1, 5'd0,  32'hEE,   1'b0, 5'd9,  32'h22,   1'b0, 1'b1, 1'b1);
        tbl[17] = mk(1'b0, 5'd0,  32'h0,    1'b0, 5'd0,  32'h0,    1'b0, 5'd9,  32'h22,   1'b0, 1'b0, 1'b1);
        tbl[18] = mk(1'b1, 5'd4,  32'h44,   1'b1, 5'd4,  32'h55,   1'b1, 5'd4,  32'h44,   1'b0, 1'b1, 1'b1);
        tbl[19] = mk(1'b0, 5'd0,  32'h0,    1'b0, 5'd0,  32'h0,    1'b0, 5'd4,  32'h44,   1'b0, 1'b0, 1'b1);

        rst_n = 1'b0;
        set_in(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        tick();
        tick();
        check_out("reset", 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b1);
        rst_n = 1'b1;

        foreach (tbl[i]) begin
            set_in(tbl[i].wv, tbl[i].wi, tbl[i].wd, tbl[i].mv, tbl[i].mi, tbl[i].md);
            tick();
            check_out($sformatf("vec%0d", i), tbl[i].we, tbl[i].idx, tbl[i].data,
                      tbl[i].stall, tbl[i].busy, tbl[i].ready);
        end

        // Starvation: WB writes every cycle while one live MDU result waits.
        set_in(1'b1, 5'd2, 32'h20, 1'b1, 5'd6, 32'h66);
        tick();
        check_out("starve0", 1'b1, 5'd2, 32'h20, 1'b0, 1'b1, 1'b1);
        set_in(1'b1, 5'd2, 32'h20, 1'b0, 5'd0, 32'h0);
        stall_cnt = 0;
        for (int i = 1; i <= 12; i++) begin
            tick();
            if (wb_stall) stall_cnt++;
            check_out($sformatf("starve%0d", i), 1'b1,
                      (i == 9) ? 5'd6 : 5'd2, (i == 9) ? 32'h66 : 32'h20,
                      (i == 8), (i <= 8), 1'b1);
        end
        chk("starve_stall_cycles", 32'(stall_cnt), 32'd1);

        // Reset with two results buffered: neither may ever reach the register file.
        set_in(1'b1, 5'd1, 32'h01, 1'b1, 5'd13, 32'hD);
        tick();
        set_in(1'b1, 5'd1, 32'h01, 1'b1, 5'd14, 32'hE);
        tick();
        check_out("prerst", 1'b1, 5'd1, 32'h01, 1'b0, 1'b1, 1'b0);
        rst_n = 1'b0;
        set_in(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        tick();
        rst_n = 1'b1;
        check_out("midrst", 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_out($sformatf("postrst%0d", i), 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b1);
        end

        // Random traffic against the reference model.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        mq.delete();
        m_age = 0; m_force = 1'b0; m_we = 1'b0; m_idx = 5'd0; m_data = 32'h0;
        stuck = 1'b0;
        for (int c = 0; c < 600; c++) begin
            phase = (c / 100) % 3;
            rdy = (mq.size() < DEPTH);
            if (!stuck) begin
                mdu_valid = ($urandom_range(0, 1) == 1);
                mdu_idx   = 5'($urandom_range(0, 7));
                mdu_data  = $urandom;
            end
            if (phase == 2) begin
                wb_valid = 1'b1;
                wb_idx   = 5'($urandom_range(1, 7));
            end else begin
                wb_valid = ($urandom_range(0, 9) < ((phase == 0) ? 5 : 9));
                wb_idx   = 5'($urandom_range(0, 7));
            end
            wb_data = $urandom;
            @(posedge clk);
            model_step();
            #1;
            chk("rnd_we",    32'(rf_we),     32'(m_we));
            chk("rnd_idx",   32'(rf_idx),    32'(m_idx));
            chk("rnd_data",  rf_data,        m_data);
            chk("rnd_stall", 32'(wb_stall),  32'(m_force));
            chk("rnd_busy",  32'(busy),      32'(mq.size() != 0));
            chk("rnd_ready", 32'(mdu_ready), 32'(mq.size() < DEPTH));
            stuck = mdu_valid && !rdy;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
